// File: rtl/matrix_stream_tx_if.sv
// Handshake bundle for matrix_stream_tx: packed-matrix load side and element-serial output side.
// master drives the load side and consumes elements; slave is the serializer.
interface matrix_stream_tx_if #(
  parameter int H          = 4,
  parameter int W          = 3,
  parameter int DATA_WIDTH = 16
);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [H*W*DATA_WIDTH-1:0] in_mat;
  logic                      in_col_major;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [RW-1:0]             out_row;
  logic [CW-1:0]             out_col;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;

  modport master (
    output in_mat, in_col_major, in_valid, out_ready,
    input  in_ready, out_data, out_row, out_col, out_last, out_valid, busy
  );

  modport slave (
    input  in_mat, in_col_major, in_valid, out_ready,
    output in_ready, out_data, out_row, out_col, out_last, out_valid, busy
  );
endinterface

// File: rtl/matrix_stream_tx.sv
// Captures one packed HxW fixed-point matrix and streams its elements one per handshake,
// row- or column-major, with row/col indices and a last flag attached to each element.
module matrix_stream_tx #(
  parameter int H           = 4,
  parameter int W           = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  matrix_stream_tx_if.slave  bus
);
  localparam int N  = H * W;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);

  // Data is never interpreted, so the fraction width only needs to be sane.
  if (FRACT_WIDTH > DATA_WIDTH) begin : g_fract_check
    $error("matrix_stream_tx: FRACT_WIDTH exceeds DATA_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mat_q [N];
  logic [DATA_WIDTH-1:0] mat_d [N];
  logic                  col_major_q, col_major_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic [RW-1:0]         nxt_row;
  logic [CW-1:0]         nxt_col;
  logic [IW-1:0]         nxt_idx;

  always_comb begin
    state_d     = state_q;
    mat_d       = mat_q;
    col_major_d = col_major_q;
    row_d       = row_q;
    col_d       = col_q;
    data_d      = data_q;
    last_d      = last_q;
    valid_d     = valid_q;
    ready_d     = ready_q;

    // Successor position; only consumed when the current element is not the last.
    nxt_row = row_q;
    nxt_col = col_q;
    if (!col_major_q) begin
      if (col_q == COL_MAX) begin
        nxt_col = '0;
        nxt_row = row_q + RW'(1);
      end else begin
        nxt_col = col_q + CW'(1);
      end
    end else begin
      if (row_q == ROW_MAX) begin
        nxt_row = '0;
        nxt_col = col_q + CW'(1);
      end else begin
        nxt_row = row_q + RW'(1);
      end
    end
    nxt_idx = IW'(int'(nxt_row) * W + int'(nxt_col));

    case (state_q)
      IDLE: begin
        if (bus.in_valid && ready_q) begin
          for (int i = 0; i < N; i++) begin
            mat_d[i] = bus.in_mat[i*DATA_WIDTH +: DATA_WIDTH];
          end
          state_d     = SEND;
          col_major_d = bus.in_col_major;
          row_d       = '0;
          col_d       = '0;
          data_d      = bus.in_mat[DATA_WIDTH-1:0];
          last_d      = (N == 1);
          valid_d     = 1'b1;
          ready_d     = 1'b0;
        end
      end
      SEND: begin
        if (valid_q && bus.out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
            last_d  = 1'b0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            row_d  = nxt_row;
            col_d  = nxt_col;
            data_d = mat_q[nxt_idx];
            last_d = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < N; i++) begin
        mat_q[i] <= '0;
      end
      col_major_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      mat_q       <= mat_d;
      col_major_q <= col_major_d;
      row_q       <= row_d;
      col_q       <= col_d;
      data_q      <= data_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == SEND);
endmodule

// File: tb/tb_matrix_stream_tx.sv
// Directed bench for matrix_stream_tx: 4x3 main instance plus 1x1 and 2x5 size variants.
module tb_matrix_stream_tx;
  localparam int H  = 4;
  localparam int W  = 3;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_stream_tx_if #(.H(4), .W(3), .DATA_WIDTH(16)) b0 ();
  matrix_stream_tx_if #(.H(1), .W(1), .DATA_WIDTH(16)) b1 ();
  matrix_stream_tx_if #(.H(2), .W(5), .DATA_WIDTH(16)) b2 ();

  matrix_stream_tx #(.H(4), .W(3), .DATA_WIDTH(16), .FRACT_WIDTH(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  matrix_stream_tx #(.H(1), .W(1), .DATA_WIDTH(16), .FRACT_WIDTH(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  matrix_stream_tx #(.H(2), .W(5), .DATA_WIDTH(16), .FRACT_WIDTH(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  int total = 0;
  int bad = 0;
  logic [15:0] em [12];
  logic [15:0] e2 [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load0(input bit cm, input bit keep);
    for (int i = 0; i < H*W; i++) b0.in_mat[i*DW +: DW] = em[i];
    b0.in_col_major = cm;
    b0.in_valid = 1'b1;
    @(negedge clk);
    if (!keep) b0.in_valid = 1'b0;
    chk("load_out_valid", b0.out_valid, 1);
    chk("load_busy", b0.busy, 1);
    chk("load_in_ready", b0.in_ready, 0);
  endtask

  // Checks n elements in the expected order, optionally with random stalls.
  task automatic stream0(input bit cm, input bit stall, input int n);
    int k = 0;
    int r, c;
    bit stalled = 0;
    bit rdy;
    logic [15:0] pd = '0;
    for (int cyc = 0; cyc < 400 && k < n; cyc++) begin
      if (b0.out_valid) begin
        if (cm) begin r = k % H; c = k / H; end
        else    begin r = k / W; c = k % W; end
        chk("data", b0.out_data, em[r*W+c]);
        chk("row", b0.out_row, r);
        chk("col", b0.out_col, c);
        chk("last", b0.out_last, (k == H*W-1));
        chk("in_ready_send", b0.in_ready, 0);
        if (stalled) chk("stall_hold", b0.out_data, pd);
        if (stall) rdy = ((cyc % 4 == 0) || (cyc % 4 == 3)) && ($urandom_range(0, 3) != 0);
        else       rdy = 1'b1;
        b0.out_ready = rdy;
        pd = b0.out_data;
        stalled = !rdy;
        if (rdy) k++;
      end
      @(negedge clk);
    end
    chk("handshakes", k, n);
    if (n == H*W) begin
      chk("end_out_valid", b0.out_valid, 0);
      chk("end_in_ready", b0.in_ready, 1);
      chk("end_busy", b0.busy, 0);
    end
    b0.out_ready = 1'b1;
  endtask

  task automatic sweep25(input bit cm);
    int k = 0;
    int r, c;
    for (int i = 0; i < 10; i++) b2.in_mat[i*DW +: DW] = e2[i];
    b2.in_col_major = cm;
    b2.in_valid = 1'b1;
    b2.out_ready = 1'b1;
    @(negedge clk);
    b2.in_valid = 1'b0;
    for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
      if (b2.out_valid) begin
        if (cm) begin r = k % 2; c = k / 2; end
        else    begin r = k / 5; c = k % 5; end
        chk("s25_data", b2.out_data, e2[r*5+c]);
        chk("s25_row", b2.out_row, r);
        chk("s25_col", b2.out_col, c);
        chk("s25_last", b2.out_last, (k == 9));
        k++;
      end
      @(negedge clk);
    end
    chk("s25_count", k, 10);
    chk("s25_end_valid", b2.out_valid, 0);
    chk("s25_end_in_ready", b2.in_ready, 1);
  endtask

  initial begin
    b0.in_mat = '0; b0.in_col_major = 1'b0; b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    b1.in_mat = '0; b1.in_col_major = 1'b0; b1.in_valid = 1'b0; b1.out_ready = 1'b1;
    b2.in_mat = '0; b2.in_col_major = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", b0.in_ready, 1);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out_last", b0.out_last, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_out_data", b0.out_data, 0);
    chk("rst_out_row", b0.out_row, 0);
    chk("rst_out_col", b0.out_col, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // all 0.25, row-major, no stalls
    for (int k = 0; k < 12; k++) em[k] = 16'h0040;
    load0(1'b0, 1'b0);
    stream0(1'b0, 1'b0, 12);

    // k<<6 with odd k negated, column-major
    for (int k = 0; k < 12; k++) em[k] = (k % 2 == 1) ? 16'(-(k << 6)) : 16'(k << 6);
    load0(1'b1, 1'b0);
    stream0(1'b1, 1'b0, 12);

    // backpressure
    for (int k = 0; k < 12; k++) em[k] = 16'(k * 613 + 7);
    load0(1'b0, 1'b0);
    stream0(1'b0, 1'b1, 12);

    // new matrix presented while busy is ignored until IDLE
    for (int k = 0; k < 12; k++) em[k] = 16'(16'hA000 + k);
    load0(1'b0, 1'b1);
    for (int k = 0; k < 12; k++) b0.in_mat[k*DW +: DW] = 16'(16'h5000 + k * 3);
    stream0(1'b0, 1'b0, 12);
    for (int k = 0; k < 12; k++) em[k] = 16'(16'h5000 + k * 3);
    @(negedge clk);
    b0.in_valid = 1'b0;
    chk("second_load_valid", b0.out_valid, 1);
    stream0(1'b0, 1'b0, 12);

    // reset after the 5th handshake
    for (int k = 0; k < 12; k++) em[k] = 16'(16'hC000 | k);
    load0(1'b0, 1'b0);
    stream0(1'b0, 1'b0, 5);
    chk("pre_rst_row", b0.out_row, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", b0.out_valid, 0);
    chk("arst_busy", b0.busy, 0);
    chk("arst_in_ready", b0.in_ready, 1);
    chk("arst_out_row", b0.out_row, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load0(1'b1, 1'b0);
    stream0(1'b1, 1'b0, 12);

    // 1x1
    b1.in_mat = 16'h8001;
    b1.in_valid = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    chk("s11_valid", b1.out_valid, 1);
    chk("s11_data", b1.out_data, 16'h8001);
    chk("s11_row", b1.out_row, 0);
    chk("s11_col", b1.out_col, 0);
    chk("s11_last", b1.out_last, 1);
    @(negedge clk);
    chk("s11_end_valid", b1.out_valid, 0);
    chk("s11_end_in_ready", b1.in_ready, 1);

    // 2x5 both orders
    for (int i = 0; i < 10; i++) e2[i] = 16'(i * 16'h0101 + 16'h8003);
    sweep25(1'b0);
    sweep25(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
